vga_scan_ctrl: RTL and testbench

//  Raster timing generator driving the VGA port and the draw_field renderer.

---
 rtl/vga_scan_ctrl_pkg.sv | 31 +++
 rtl/vga_scan_ctrl_axis.sv | 44 ++++
 rtl/vga_scan_ctrl.sv | 113 +++++++++++
 tb/tb_vga_scan_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_scan_ctrl_pkg.sv
// Shared VGA timing defaults, colour codes and counter helpers for the raster generator.
package vga_scan_ctrl_pkg;

  localparam int CNT_W = 12;
  localparam int DIV_W = 4;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;
  localparam logic [2:0] COLOR_RED   = 3'b100;
  localparam logic [2:0] COLOR_GREEN = 3'b010;
  localparam logic [2:0] COLOR_BLUE  = 3'b001;

  // True when lo <= c < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
    int ci;
    ci = int'(c);
    return (ci >= lo) && (ci < hi);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_axis.sv
// One raster axis: wrapping position counter with active-region and sync-window decode.
module vga_scan_ctrl_axis
  import vga_scan_ctrl_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             active_o,
  output logic             sync_o,
  output logic             wrap_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_d, count_q;

  assign wrap_o   = en_i && (count_q == LAST);
  assign active_o = in_window(count_q, 0, ACTIVE);
  assign sync_o   = in_window(count_q, ACTIVE + FP, ACTIVE + FP + SYNC);
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator: pixel-rate divider, H/V scan counters, registered
// colour/sync/display-enable output stage and a once-per-frame game tick.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [2:0]        color_i,
  output logic [CNT_W-1:0]  pixel_x_o,
  output logic [CNT_W-1:0]  pixel_y_o,
  output logic [2:0]        vga_rgb_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o,
  output logic              frame_tick_o
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_d, div_q;
  logic             pix_en;
  logic             h_active, h_sync, h_wrap;
  logic             v_active, v_sync, v_wrap;
  logic [2:0]       rgb_d, rgb_q;
  logic             de_d, de_q;
  logic             hs_d, hs_q;
  logic             vs_d, vs_q;
  logic             tick_d, tick_q;

  assign pix_en = (div_q == DIV_LAST);

  vga_scan_ctrl_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (pix_en),
    .count_o  (pixel_x_o),
    .active_o (h_active),
    .sync_o   (h_sync),
    .wrap_o   (h_wrap)
  );

  // h_wrap already implies pix_en, so V steps once per completed line.
  vga_scan_ctrl_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (h_wrap),
    .count_o  (pixel_y_o),
    .active_o (v_active),
    .sync_o   (v_sync),
    .wrap_o   (v_wrap)
  );

  always_comb begin
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);
    rgb_d  = rgb_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    tick_d = v_wrap;
    if (pix_en) begin
      de_d  = h_active && v_active;
      rgb_d = (h_active && v_active) ? color_i : COLOR_BLACK;
      hs_d  = h_sync ? SYNC_POL : ~SYNC_POL;
      vs_d  = v_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      div_q  <= '0;
      rgb_q  <= COLOR_BLACK;
      de_q   <= 1'b0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      rgb_q  <= rgb_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= tick_d;
    end
  end

  assign vga_rgb_o    = rgb_q;
  assign de_o         = de_q;
  assign hsync_o      = hs_q;
  assign vsync_o      = vs_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl: two instances (CLK_DIV=2 and 1) on a reduced raster,
// expected outputs derived from the elapsed clock count since reset.
module tb_vga_scan_ctrl;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  if (HT > 4096 || VT > 4096) begin : g_total_chk
    $error("raster totals exceed the 12-bit counter range");
  end

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  color;
  logic [11:0] x2, y2, x1, y1;
  logic [2:0]  rgb2, rgb1;
  logic        hs2, vs2, de2, tk2, hs1, vs1, de1, tk1;

  int total = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  int         mk[2];
  logic [2:0] mrgb[2];

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_d2 (
    .clk_i(clk), .rst_n_i(rst_n), .color_i(color),
    .pixel_x_o(x2), .pixel_y_o(y2), .vga_rgb_o(rgb2),
    .hsync_o(hs2), .vsync_o(vs2), .de_o(de2), .frame_tick_o(tk2)
  );

  vga_scan_ctrl #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
  ) u_d1 (
    .clk_i(clk), .rst_n_i(rst_n), .color_i(color),
    .pixel_x_o(x1), .pixel_y_o(y1), .vga_rgb_o(rgb1),
    .hsync_o(hs1), .vsync_o(vs1), .de_o(de1), .frame_tick_o(tk1)
  );

  // After k clocks of scanning, k/d pixels have been consumed; outputs describe the previous one.
  function automatic exp_t model_out(input int d, input int k, input logic [2:0] rgb);
    exp_t e;
    int p, q, qh, qv;
    p      = k / d;
    e.x    = 12'(p % HT);
    e.y    = 12'((p / HT) % VT);
    e.rgb  = rgb;
    e.hs   = 1'b1;
    e.vs   = 1'b1;
    e.de   = 1'b0;
    e.tick = 1'b0;
    if (p > 0) begin
      q      = p - 1;
      qh     = q % HT;
      qv     = (q / HT) % VT;
      e.de   = (qh < HA) && (qv < VA);
      e.hs   = !((qh >= HA + HFP) && (qh < HA + HFP + HS));
      e.vs   = !((qv >= VA + VFP) && (qv < VA + VFP + VS));
      e.tick = (k % d == 0) && (p % (HT * VT) == 0);
    end
    return e;
  endfunction

  task automatic cycle(input logic r, input logic [2:0] c);
    int d, q, qh, qv;
    @(negedge clk);
    rst_n = r;
    color = c;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? 2 : 1;
      if (!r) begin
        mk[i]   = 0;
        mrgb[i] = 3'b000;
      end else begin
        mk[i] = mk[i] + 1;
        if (mk[i] % d == 0) begin
          q  = mk[i] / d - 1;
          qh = q % HT;
          qv = (q / HT) % VT;
          mrgb[i] = ((qh < HA) && (qv < VA)) ? c : 3'b000;
        end
      end
      if (i == 0) q0.push_back(model_out(d, mk[i], mrgb[i]));
      else        q1.push_back(model_out(d, mk[i], mrgb[i]));
    end
  endtask

  task automatic chk(input string nm, input int inst, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s div%0d at %0t: got=%0h want=%0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic compare(input int inst, input exp_t e, input logic [11:0] x, input logic [11:0] y,
                         input logic [2:0] rgb, input logic hs, input logic vs, input logic de,
                         input logic tk);
    chk("pixel_x", inst, x, e.x);
    chk("pixel_y", inst, y, e.y);
    chk("rgb", inst, 12'(rgb), 12'(e.rgb));
    chk("hsync", inst, 12'(hs), 12'(e.hs));
    chk("vsync", inst, 12'(vs), 12'(e.vs));
    chk("de", inst, 12'(de), 12'(e.de));
    chk("frame_tick", inst, 12'(tk), 12'(e.tick));
  endtask

  // Monitor: one expectation per instance per active edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        compare(2, e, x2, y2, rgb2, hs2, vs2, de2, tk2);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        compare(1, e, x1, y1, rgb1, hs1, vs1, de1, tk1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    color = 3'b000;
    mk[0] = 0; mk[1] = 0;
    mrgb[0] = 3'b000; mrgb[1] = 3'b000;
    repeat (3) cycle(1'b0, 3'($urandom));
    repeat (700) cycle(1'b1, 3'($urandom));
    repeat (350) cycle(1'b1, 3'b101);
    repeat (37) cycle(1'b1, 3'($urandom));
    cycle(1'b0, 3'($urandom));
    repeat (700) cycle(1'b1, 3'($urandom));
    repeat (4) begin
      repeat ($urandom_range(20, 200)) cycle(1'b1, 3'($urandom));
      cycle(1'b0, 3'($urandom));
    end
    repeat (400) cycle(1'b1, 3'($urandom));
    @(posedge clk);
    #2;
    chk("drain_q0", 2, 12'(q0.size()), 12'd0);
    chk("drain_q1", 1, 12'(q1.size()), 12'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
